// File: rtl/mul_eval_pkg.sv
// rtl/mul_eval_pkg.sv - shared types, widths and saturating add for the multiplier error monitor
//
// Contents:
//   state_t     batch FSM states (IDLE, RUN, DRAIN, DONE)
//   W_DEF       default operand width
//   PROD_W_DEF  default product width (2*W_DEF)
//   SAT_ACC_W   width of the generic saturating adder
//   sat_add     {saturated, min(acc+inc, 2^width-1)} on SAT_ACC_W-bit operands
package mul_eval_pkg;

    localparam int W_DEF      = 16;
    localparam int PROD_W_DEF = 2 * W_DEF;
    localparam int SAT_ACC_W  = 64;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // Callers zero-extend into 64 bits and pass their real width; the
    // returned MSB flags that the true sum exceeded the width's maximum.
    function automatic logic [SAT_ACC_W:0] sat_add(
        input logic [SAT_ACC_W-1:0] acc,
        input logic [SAT_ACC_W-1:0] inc,
        input int unsigned          width
    );
        logic [SAT_ACC_W:0]   sum;
        logic [SAT_ACC_W-1:0] limit;
        sum = {1'b0, acc} + {1'b0, inc};
        if (width >= SAT_ACC_W) begin
            limit = '1;
        end else begin
            limit = (SAT_ACC_W'(1) << width) - SAT_ACC_W'(1);
        end
        if (sum > {1'b0, limit}) begin
            sat_add = {1'b1, limit};
        end else begin
            sat_add = sum;
        end
    endfunction

endpackage

// File: rtl/mul_error_accumulator_abs_err_stage.sv
// rtl/mul_error_accumulator_abs_err_stage.sv - two-stage exact multiply and absolute error pipeline
//
// Ports:
//   clk, rst_n     clock, asynchronous active-low reset
//   i_valid        triple accepted this cycle
//   i_a, i_b       operands (W bits)
//   i_c            approximate product (2*W bits)
//   o_valid        S2 holds a valid error sample
//   o_err          |a*b - c| of the S2 sample
//   o_a, o_b       operands of the S2 sample
//   o_busy         any stage holds a valid sample
module abs_err_stage #(
    parameter int W = 16
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           i_valid,
    input  logic [W-1:0]   i_a,
    input  logic [W-1:0]   i_b,
    input  logic [2*W-1:0] i_c,
    output logic           o_valid,
    output logic [2*W-1:0] o_err,
    output logic [W-1:0]   o_a,
    output logic [W-1:0]   o_b,
    output logic           o_busy
);

    localparam int PW = 2 * W;

    logic          r_s1_valid;
    logic [W-1:0]  r_s1_a;
    logic [W-1:0]  r_s1_b;
    logic [PW-1:0] r_s1_c;

    logic          r_s2_valid;
    logic [PW-1:0] r_s2_err;
    logic [W-1:0]  r_s2_a;
    logic [W-1:0]  r_s2_b;

    logic [PW-1:0] w_exact;
    logic [PW-1:0] w_err;

    assign w_exact = PW'(r_s1_a) * PW'(r_s1_b);
    assign w_err   = (w_exact >= r_s1_c) ? (w_exact - r_s1_c) : (r_s1_c - w_exact);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_valid <= 1'b0;
            r_s1_a     <= '0;
            r_s1_b     <= '0;
            r_s1_c     <= '0;
            r_s2_valid <= 1'b0;
            r_s2_err   <= '0;
            r_s2_a     <= '0;
            r_s2_b     <= '0;
        end else begin
            r_s1_valid <= i_valid;
            if (i_valid) begin
                r_s1_a <= i_a;
                r_s1_b <= i_b;
                r_s1_c <= i_c;
            end
            r_s2_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_s2_err <= w_err;
                r_s2_a   <= r_s1_a;
                r_s2_b   <= r_s1_b;
            end
        end
    end

    assign o_valid = r_s2_valid;
    assign o_err   = r_s2_err;
    assign o_a     = r_s2_a;
    assign o_b     = r_s2_b;
    assign o_busy  = r_s1_valid | r_s2_valid;

endmodule

// File: rtl/mul_error_accumulator.sv
// rtl/mul_error_accumulator.sv - batch error-statistics monitor for an approximate 16x16 multiplier
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   start, target         begin a batch of target samples (accepted in IDLE/DONE)
//   in_valid, in_ready    triple handshake
//   a, b, c_approx        operands and approximate product
//   busy, done            batch status (RUN|DRAIN, DONE)
//   err_sum, sum_sat      saturating sum of absolute error, sticky saturation flag
//   err_max, max_a, max_b largest error and its operands
//   mismatch_cnt          samples with nonzero error (saturating)
//   sample_cnt            samples accumulated (saturating)
// SUM_W must lie in [2*W, 63].
module mul_error_accumulator
    import mul_eval_pkg::*;
#(
    parameter int W     = W_DEF,
    parameter int SUM_W = 48,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [CNT_W-1:0] target,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W-1:0]     a,
    input  logic [W-1:0]     b,
    input  logic [2*W-1:0]   c_approx,
    output logic             busy,
    output logic             done,
    output logic [SUM_W-1:0] err_sum,
    output logic             sum_sat,
    output logic [2*W-1:0]   err_max,
    output logic [W-1:0]     max_a,
    output logic [W-1:0]     max_b,
    output logic [CNT_W-1:0] mismatch_cnt,
    output logic [CNT_W-1:0] sample_cnt
);

    localparam int PW = 2 * W;

    state_t r_state;
    state_t w_state_next;

    logic [CNT_W-1:0] r_target;
    logic [CNT_W-1:0] r_issued;

    logic [SUM_W-1:0] r_err_sum;
    logic             r_sum_sat;
    logic [PW-1:0]    r_err_max;
    logic [W-1:0]     r_max_a;
    logic [W-1:0]     r_max_b;
    logic [CNT_W-1:0] r_mismatch;
    logic [CNT_W-1:0] r_sample;

    logic w_start_ok;
    logic w_in_ready;
    logic w_xfer;

    logic          w_s2_valid;
    logic [PW-1:0] w_s2_err;
    logic [W-1:0]  w_s2_a;
    logic [W-1:0]  w_s2_b;
    logic          w_pipe_busy;

    assign w_start_ok = start && ((r_state == ST_IDLE) || (r_state == ST_DONE));
    assign w_in_ready = (r_state == ST_RUN) && (r_issued < r_target);
    assign w_xfer     = in_valid && w_in_ready;

    abs_err_stage #(
        .W (W)
    ) u_abs_err_stage (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_valid (w_xfer),
        .i_a     (a),
        .i_b     (b),
        .i_c     (c_approx),
        .o_valid (w_s2_valid),
        .o_err   (w_s2_err),
        .o_a     (w_s2_a),
        .o_b     (w_s2_b),
        .o_busy  (w_pipe_busy)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // RUN leaves once every requested sample has been issued; DRAIN waits
    // until the last sample has left S2 so DONE implies final statistics.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE:  if (start) w_state_next = ST_RUN;
            ST_RUN:   if (r_issued == r_target) w_state_next = ST_DRAIN;
            ST_DRAIN: if (!w_pipe_busy) w_state_next = ST_DONE;
            ST_DONE:  if (start) w_state_next = ST_RUN;
            default:  w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_target <= '0;
            r_issued <= '0;
        end else if (w_start_ok) begin
            r_target <= target;
            r_issued <= '0;
        end else if (w_xfer) begin
            r_issued <= r_issued + CNT_W'(1);
        end
    end

    // Saturating adders share one 64-bit helper; bits above each
    // register's width are always zero after saturation and are dropped.
    logic [SAT_ACC_W:0]         w_sum_add;
    logic [SAT_ACC_W:0]         w_mis_add;
    logic [SAT_ACC_W:0]         w_smp_add;
    logic                       w_sum_ovf;
    logic [SAT_ACC_W-SUM_W-1:0] w_sum_pad_unused;
    logic [SUM_W-1:0]           w_sum_next;
    logic [SAT_ACC_W-CNT_W:0]   w_mis_pad_unused;
    logic [CNT_W-1:0]           w_mis_next;
    logic [SAT_ACC_W-CNT_W:0]   w_smp_pad_unused;
    logic [CNT_W-1:0]           w_smp_next;

    assign w_sum_add = sat_add(SAT_ACC_W'(r_err_sum), SAT_ACC_W'(w_s2_err), SUM_W);
    assign w_mis_add = sat_add(SAT_ACC_W'(r_mismatch), SAT_ACC_W'(1), CNT_W);
    assign w_smp_add = sat_add(SAT_ACC_W'(r_sample), SAT_ACC_W'(1), CNT_W);

    assign {w_sum_ovf, w_sum_pad_unused, w_sum_next} = w_sum_add;
    assign {w_mis_pad_unused, w_mis_next}            = w_mis_add;
    assign {w_smp_pad_unused, w_smp_next}            = w_smp_add;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err_sum  <= '0;
            r_sum_sat  <= 1'b0;
            r_err_max  <= '0;
            r_max_a    <= '0;
            r_max_b    <= '0;
            r_mismatch <= '0;
            r_sample   <= '0;
        end else if (w_start_ok) begin
            r_err_sum  <= '0;
            r_sum_sat  <= 1'b0;
            r_err_max  <= '0;
            r_max_a    <= '0;
            r_max_b    <= '0;
            r_mismatch <= '0;
            r_sample   <= '0;
        end else if (w_s2_valid) begin
            r_err_sum <= w_sum_next;
            if (w_sum_ovf) begin
                r_sum_sat <= 1'b1;
            end
            // Strict compare: ties keep the earlier sample, and zero
            // errors never displace the cleared operands.
            if (w_s2_err > r_err_max) begin
                r_err_max <= w_s2_err;
                r_max_a   <= w_s2_a;
                r_max_b   <= w_s2_b;
            end
            if (w_s2_err != '0) begin
                r_mismatch <= w_mis_next;
            end
            r_sample <= w_smp_next;
        end
    end

    assign in_ready     = w_in_ready;
    assign busy         = (r_state == ST_RUN) || (r_state == ST_DRAIN);
    assign done         = (r_state == ST_DONE);
    assign err_sum      = r_err_sum;
    assign sum_sat      = r_sum_sat;
    assign err_max      = r_err_max;
    assign max_a        = r_max_a;
    assign max_b        = r_max_b;
    assign mismatch_cnt = r_mismatch;
    assign sample_cnt   = r_sample;

endmodule

// File: tb/tb_mul_error_accumulator.sv
// tb/tb_mul_error_accumulator.sv - directed self-checking bench for mul_error_accumulator
module tb_mul_error_accumulator;

    localparam int W     = 16;
    localparam int SUM_W = 33;
    localparam int CNT_W = 16;

    logic             clk;
    logic             rst_n;
    logic             start;
    logic [CNT_W-1:0] target;
    logic             in_valid;
    logic             in_ready;
    logic [W-1:0]     a;
    logic [W-1:0]     b;
    logic [2*W-1:0]   c_approx;
    logic             busy;
    logic             done;
    logic [SUM_W-1:0] err_sum;
    logic             sum_sat;
    logic [2*W-1:0]   err_max;
    logic [W-1:0]     max_a;
    logic [W-1:0]     max_b;
    logic [CNT_W-1:0] mismatch_cnt;
    logic [CNT_W-1:0] sample_cnt;

    int n_checks;
    int n_fail;

    mul_error_accumulator #(
        .W     (W),
        .SUM_W (SUM_W),
        .CNT_W (CNT_W)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .target       (target),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .a            (a),
        .b            (b),
        .c_approx     (c_approx),
        .busy         (busy),
        .done         (done),
        .err_sum      (err_sum),
        .sum_sat      (sum_sat),
        .err_max      (err_max),
        .max_a        (max_a),
        .max_b        (max_b),
        .mismatch_cnt (mismatch_cnt),
        .sample_cnt   (sample_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // All tasks start and end at posedge+1.
    task automatic do_start(input int tgt);
        start  = 1'b1;
        target = CNT_W'(tgt);
        @(posedge clk);
        #1;
        start  = 1'b0;
    endtask

    task automatic send(input int va, input int vb, input longint vc);
        int n;
        a        = W'(va);
        b        = W'(vb);
        c_approx = 32'(vc);
        in_valid = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!in_ready && n < 20);
        if (!in_ready) check("send_ready_timeout", 0, 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int budget, output int cycles);
        cycles = 0;
        forever begin
            @(negedge clk);
            cycles++;
            if (done) break;
            if (cycles >= budget) begin
                check(tag, 0, 1);
                break;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic check_stats(input string tag, input longint s, input logic sat, input longint mx,
                               input int ma, input int mb, input int mis, input int smp);
        check({tag, "_err_sum"}, 64'(err_sum), 64'(s));
        check({tag, "_sum_sat"}, 64'(sum_sat), 64'(sat));
        check({tag, "_err_max"}, 64'(err_max), 64'(mx));
        check({tag, "_max_a"}, 64'(max_a), 64'(ma));
        check({tag, "_max_b"}, 64'(max_b), 64'(mb));
        check({tag, "_mismatch"}, 64'(mismatch_cnt), 64'(mis));
        check({tag, "_samples"}, 64'(sample_cnt), 64'(smp));
    endtask

    initial begin
        int cyc;
        int xfers;
        int nbusy;
        logic [7:0] pat;

        n_checks = 0;
        n_fail   = 0;
        rst_n    = 1'b1;
        start    = 1'b0;
        target   = '0;
        in_valid = 1'b0;
        a        = '0;
        b        = '0;
        c_approx = '0;

        #1 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready", 64'(in_ready), 0);
        check("rst_busy", 64'(busy), 0);
        check("rst_done", 64'(done), 0);
        check_stats("rst", 0, 1'b0, 0, 0, 0, 0, 0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Basic batch: errors 0, 1000, 6.
        do_start(3);
        check("basic_busy", 64'(busy), 1);
        check("basic_done_dropped", 64'(done), 0);
        send(3, 5, 15);
        send(1000, 1000, 999000);
        send(2, 2, 10);
        wait_done("basic_done_timeout", 20, cyc);
        check("basic_done_latency_le4", 64'(cyc <= 4), 1);
        check("basic_busy_after", 64'(busy), 0);
        check_stats("basic", 1006, 1'b0, 1000, 1000, 1000, 2, 3);

        // Tie on error 6: earlier sample kept.
        do_start(2);
        send(4, 4, 10);
        send(5, 5, 19);
        wait_done("tie_done_timeout", 20, cyc);
        check_stats("tie", 12, 1'b0, 6, 4, 4, 2, 2);

        // Saturation of a 33-bit sum with three errors of 0xFFFE0001.
        do_start(3);
        send(65535, 65535, 0);
        send(65535, 65535, 0);
        send(65535, 65535, 0);
        wait_done("sat_done_timeout", 20, cyc);
        check_stats("sat", 64'h1_FFFF_FFFF, 1'b1, 64'hFFFE_0001, 65535, 65535, 3, 3);

        // Throughput with gaps; cycles 6 and 7 offer extra triples.
        pat   = 8'b1110_1101;
        xfers = 0;
        do_start(4);
        for (int i = 0; i < 8; i++) begin
            in_valid = pat[i];
            a        = W'(xfers + 2);
            b        = W'(xfers + 2);
            c_approx = 32'((xfers + 2) * (xfers + 2) + 1);
            @(negedge clk);
            if (in_valid && in_ready) xfers++;
            @(posedge clk);
            #1;
        end
        check("thr_transfers", 64'(xfers), 4);
        check("thr_ready_low", 64'(in_ready), 0);
        in_valid = 1'b0;
        wait_done("thr_done_timeout", 20, cyc);
        check_stats("thr", 4, 1'b0, 1, 2, 2, 4, 4);

        // Empty batch.
        do_start(0);
        check("t0_ready", 64'(in_ready), 0);
        nbusy = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (done) break;
            if (busy) nbusy++;
        end
        check("t0_busy_cycles", 64'(nbusy), 2);
        check("t0_done", 64'(done), 1);
        check_stats("t0", 0, 1'b0, 0, 0, 0, 0, 0);
        @(posedge clk);
        #1;

        // Reset mid-RUN abandons the batch.
        do_start(5);
        send(7, 7, 50);
        send(3, 3, 0);
        repeat (3) @(posedge clk);
        #1;
        check("mid_pre_samples", 64'(sample_cnt), 2);
        check("mid_pre_sum", 64'(err_sum), 10);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_busy", 64'(busy), 0);
        check("mid_rst_done", 64'(done), 0);
        check("mid_rst_ready", 64'(in_ready), 0);
        check_stats("mid_rst", 0, 1'b0, 0, 0, 0, 0, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        do_start(1);
        send(7, 7, 49);
        wait_done("post_done_timeout", 20, cyc);
        check_stats("post", 0, 1'b0, 0, 0, 0, 0, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
